systolic_ctrl: RTL and testbench

- Sequencer for the output-stationary ROWS x COLS PE array. Each PE accumulates `in_w*in_a` while `fire` is high, forwards `in_a` and `fire` east, and has a synchronous active-low clear.
- On `start`, the block:
  - clears all accumulators,
  - streams K operand beats from the A/W operand buffers,
  - generates the row-skewed `fire` wavefront,
  - waits for the wavefront to leave the array,
  - drains results one row at a time over a valid/ready port.
- Sits between the host command interface and the array plus operand buffers.

---
 rtl/systola_pkg.sv | 26 ++
 rtl/skew_shreg.sv | 27 ++
 rtl/systolic_ctrl.sv | 172 +++++++++++++++++
 tb/tb_systolic_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/systola_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systola_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } ctrl_state_t;

  localparam int DEF_ROWS  = 4;
  localparam int DEF_COLS  = 4;
  localparam int DEF_K_W   = 8;
  localparam int FLUSH_CYC = DEF_ROWS + DEF_COLS;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/skew_shreg.sv
// Staircase of 1-cycle delays: q_o[i] is d_i delayed by i+1 cycles.
module skew_shreg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] sh_q;

  // Each stage takes the previous stage's value; stage 0 takes the input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q <= '0;
    end else begin
      sh_q[0] <= d_i;
      for (int i = 1; i < N; i++) begin
        sh_q[i] <= sh_q[i-1];
      end
    end
  end

  assign q_o = sh_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an output-stationary ROWS x COLS PE array: clear, feed, flush, drain.
// Optional busy-cycle counter output enabled by defining SYSTOLA_CTRL_PERF_EN.
module systolic_ctrl
  import systola_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int K_W  = DEF_K_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    arr_clr_n,
  output logic                    rd_en,
  output logic [K_W-1:0]          rd_addr,
  output logic [ROWS-1:0]         row_fire,
  output logic                    drain_valid,
  output logic [$clog2(ROWS)-1:0] drain_sel,
  input  logic                    drain_ready
`ifdef SYSTOLA_CTRL_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int SEL_W  = $clog2(ROWS);
  localparam int FL_CYC = ROWS + COLS;
  localparam int FL_W   = $clog2(FL_CYC + 1);

  ctrl_state_t      state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [K_W-1:0]   addr_q, addr_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, clr_n_q, rd_en_q, dv_q, done_q;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    fl_d    = fl_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          k_d     = k_len;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        addr_d = {K_W{1'b0}};
        if (k_q == {K_W{1'b0}}) begin
          state_d = DRAIN;
        end else begin
          state_d = FEED;
        end
      end
      FEED: begin
        // addr doubles as the beat counter; comparing against K-1 keeps K=max from wrapping
        if (addr_q == k_q - K_W'(1)) begin
          state_d = FLUSH;
          addr_d  = {K_W{1'b0}};
          fl_d    = FL_W'(FL_CYC);
        end else begin
          addr_d  = addr_q + K_W'(1);
        end
      end
      FLUSH: begin
        if (fl_q == FL_W'(1)) begin
          state_d = DRAIN;
          fl_d    = {FL_W{1'b0}};
        end else begin
          fl_d    = fl_q - FL_W'(1);
        end
      end
      DRAIN: begin
        if (drain_ready) begin
          if (sel_q == SEL_W'(ROWS - 1)) begin
            state_d = DONE;
            sel_d   = {SEL_W{1'b0}};
          end else begin
            sel_d   = sel_q + SEL_W'(1);
          end
        end else begin
          sel_d = sel_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, and outputs decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= {K_W{1'b0}};
      addr_q  <= {K_W{1'b0}};
      fl_q    <= {FL_W{1'b0}};
      sel_q   <= {SEL_W{1'b0}};
      busy_q  <= 1'b0;
      clr_n_q <= 1'b1;
      rd_en_q <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      fl_q    <= fl_d;
      sel_q   <= sel_d;
      busy_q  <= (state_d != IDLE);
      clr_n_q <= (state_d != CLEAR);
      rd_en_q <= (state_d == FEED);
      dv_q    <= (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  skew_shreg #(.N(ROWS)) u_fire_skew (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (rd_en_q),
    .q_o  (row_fire)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign arr_clr_n   = clr_n_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = addr_q;
  assign drain_valid = dv_q;
  assign drain_sel   = sel_q;

`ifdef SYSTOLA_CTRL_PERF_EN
  logic [31:0] pcnt_q, perf_q;

  // Busy-cycle counter; the DONE copy includes the DONE cycle itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt_q <= 32'd0;
      perf_q <= 32'd0;
    end else begin
      if (state_q == IDLE && start) begin
        pcnt_q <= 32'd0;
      end else if (busy_q) begin
        pcnt_q <= sat_inc32(pcnt_q);
      end else begin
        pcnt_q <= pcnt_q;
      end
      if (state_q == DONE) begin
        perf_q <= sat_inc32(pcnt_q);
      end else begin
        perf_q <= perf_q;
      end
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl against a cycle-timeline reference model.
module tb_systolic_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int K_W  = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [K_W-1:0]  k_len;
  logic            busy, done, arr_clr_n, rd_en;
  logic [K_W-1:0]  rd_addr;
  logic [ROWS-1:0] row_fire;
  logic            drain_valid;
  logic [1:0]      drain_sel;
  logic            drain_ready;
`ifdef SYSTOLA_CTRL_PERF_EN
  logic [31:0]     perf_cycles;
`endif

  int total = 0;
  int bad   = 0;
  int d_at;

  always #5 clk = ~clk;

  systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .arr_clr_n   (arr_clr_n),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .row_fire    (row_fire),
    .drain_valid (drain_valid),
    .drain_sel   (drain_sel),
    .drain_ready (drain_ready)
`ifdef SYSTOLA_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_clr"},  32'(arr_clr_n), 32'd1);
    chk({tag, "_rden"}, 32'(rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_fire"}, 32'(row_fire), 32'd0);
    chk({tag, "_dv"},   32'(drain_valid), 32'd0);
    chk({tag, "_sel"},  32'(drain_sel), 32'd0);
  endtask

  // One operation, checked every cycle against the timeline derived from K and
  // the bench's own record of drain handshakes. Cycle 0 is the cycle start is high.
  task automatic run_op(input int k, input int stall_row, input int stall_len,
                        input bit rand_rdy, input bit poke, output int done_at);
    int acc = 0;
    int last_hs = -10;
    int fin = -1;
    int stall_left = stall_len;
    int ds;
    bit dv_e, done_e, busy_e, rden_e;
    int addr_e;
    logic [ROWS-1:0] fire_e;
    done_at = -1;
    ds = (k == 0) ? 2 : 2 + k + ROWS + COLS;
    @(negedge clk);
    chk("pre_busy", 32'(busy), 32'd0);
    start = 1'b1;
    k_len = K_W'(k);
    drain_ready = 1'b1;
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && c == 3) start = 1'b1;
      rden_e = (c >= 2) && (c <= k + 1);
      addr_e = rden_e ? c - 2 : 0;
      for (int r = 0; r < ROWS; r++) fire_e[r] = (k > 0) && (c >= 3 + r) && (c <= k + 2 + r);
      dv_e   = (c >= ds) && (acc < ROWS);
      done_e = (acc == ROWS) && (c == last_hs + 1);
      busy_e = (fin < 0);
      chk("clr",   32'(arr_clr_n), 32'(c != 1));
      chk("rd_en", 32'(rd_en), 32'(rden_e));
      chk("rd_addr", 32'(rd_addr), 32'(addr_e));
      chk("row_fire", 32'(row_fire), 32'(fire_e));
      chk("drain_valid", 32'(drain_valid), 32'(dv_e));
      if (dv_e) chk("drain_sel", 32'(drain_sel), 32'(acc));
      chk("done", 32'(done), 32'(done_e));
      chk("busy", 32'(busy), 32'(busy_e));
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (done_e) begin
        fin = c;
        if (poke) start = 1'b1;
      end
      if (dv_e && acc == stall_row && stall_left > 0) begin
        drain_ready = 1'b0;
        stall_left--;
      end else begin
        drain_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (dv_e && drain_ready) begin
        acc++;
        last_hs = c;
      end
      if (fin >= 0 && c == fin + 2) break;
    end
    chk("op_finished", 32'(fin >= 0), 32'd1);
    drain_ready = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    k_len = '0;
    drain_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
`ifdef SYSTOLA_CTRL_PERF_EN
    chk("reset_perf", perf_cycles, 32'd0);
`endif
    rstn = 1'b1;

    run_op(3, -1, 0, 1'b0, 1'b0, d_at);
    chk("done_cyc_k3", 32'(d_at), 32'd17);

    run_op(0, -1, 0, 1'b0, 1'b0, d_at);
    chk("done_cyc_k0", 32'(d_at), 32'd6);

    run_op(3, 2, 5, 1'b0, 1'b0, d_at);
    chk("done_cyc_stall", 32'(d_at), 32'd22);

    run_op(6, -1, 0, 1'b0, 1'b1, d_at);
    chk("done_cyc_poke", 32'(d_at), 32'd20);

    // Abort mid-FEED after four beats.
    @(negedge clk);
    start = 1'b1;
    k_len = K_W'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_addr", 32'(rd_addr), 32'd3);
    #2 rstn = 1'b0;
    #1 chk_idle_outputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;

    run_op(10, -1, 0, 1'b0, 1'b0, d_at);
    chk("done_cyc_k10", 32'(d_at), 32'd24);

    run_op(255, -1, 0, 1'b0, 1'b0, d_at);
    chk("done_cyc_k255", 32'(d_at), 32'd269);
`ifdef SYSTOLA_CTRL_PERF_EN
    chk("perf_k255", perf_cycles, 32'd269);
`endif

    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom_range(0, 40)), -1, 0, 1'b1, 1'b0, d_at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
